e_muldiv_unit: RTL and testbench
================================

// Module: e_muldiv_unit
// PURPOSE
//   E-stage multiply/divide unit; consumes HILOop/start/readHL/writeHL delivered by the D->E stage register.
//   Owns the HI/LO architectural registers and runs a multi-cycle mult/div sequence.
//   Supplies mfhi/mflo read data to the E-stage result mux.
//   Raises md_stall so the hazard unit freezes D and clears E while HI/LO traffic must wait.
// PARAMETERS
//   MULT_CYCLES  5   busy cycles for mult/multu (and madd family); legal range 1..15
//   DIV_CYCLES   10  busy cycles for div/divu; legal range 1..15
// PORTS
//   clk       in   1   clock
//   reset     in   1   synchronous, active-high
//   start     in   1   launch op in hilo_op this cycle
//   hilo_op   in   4   op code; encodings in muldiv_pkg
//   rs_val    in   32  forwarded rs operand
//   rt_val    in   32  forwarded rt operand
//   write_hl  in   2   00 none, 01 mthi, 10 mtlo; value taken from rs_val
//   read_hl   in   2   00 none, 01 HI, 10 LO
//   busy      out  1   registered; high while an op is in flight
//   md_stall  out  1   combinational: (start | busy) for hazard unit use
//   hi_o      out  32  current HI register
//   lo_o      out  32  current LO register
//   rd_hl     out  32  combinational: HI if read_hl=01, LO if 10, else 0
// BEHAVIOUR
//   Reset: busy=0, HI=0, LO=0, counter=0, staged results=0; rd_hl follows read_hl (0 when read_hl=00).
//   FSM: IDLE -> BUSY on start & legal op. BUSY -> IDLE when counter reaches 1; counter is loaded with N.
//   Timing: start sampled at edge E0. busy=1 for exactly N cycles after E0 (N = MULT_CYCLES or DIV_CYCLES).
//     HI/LO update on the edge where busy falls.
//   Operands are captured at E0: the result is computed from the E0 values and held in staging registers.
//     Later rs_val/rt_val changes have no effect on that result.
//   mult: {HI,LO} = signed rs*rt. multu: unsigned.
//   div: LO = rs/rt, HI = rs%rt, signed, truncate toward zero; remainder takes the dividend's sign.
//     divu: unsigned.
//   Divide by zero: the op runs its full DIV_CYCLES; HI and LO keep their old values.
//   0x80000000 / -1 (signed): LO=0x80000000, HI=0.
//   start while busy=1: ignored. The hazard unit must not issue it. The op in flight is unaffected.
//   start with an unknown or disabled op code: ignored; busy stays 0.
//   write_hl while idle: HI or LO takes rs_val at the next edge.
//     If the same cycle has start with a legal op, start wins and write_hl is dropped.
//   write_hl while busy: ignored.
//   Reads while busy return the pre-op HI/LO; the stall keeps architectural reads from occurring.
//   Reset mid-op: the op is aborted. Everything returns to reset values at that edge.
// CONFIGURATION
//   `MULDIV_MACC_EN defined: adds madd, maddu, msub, msubu.
//     {HI,LO} +/- rs*rt, 64-bit wrap-around, using MULT_CYCLES.
//     The accumulate base is {HI,LO} as captured at E0.
//   `MULDIV_MACC_EN undefined: those codes are illegal and are ignored as above.
//     No accumulate adder is synthesised.
// STRUCTURE
//   muldiv_pkg: hilo_op encodings (NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MADD=5, MADDU=6, MSUB=7, MSUBU=8).
//     Also holds the write_hl/read_hl encodings and an is_div() helper.
//   Sub-module muldiv_datapath: combinational 64-bit product, quotient/remainder and MACC adder.
//     The top level holds the FSM, counter, staging registers and HI/LO.
// TESTING
//   1 mult: rs=0xFFFFFFFE(-2), rt=3, start -> busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
//   2 multu with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
//   3 div: rs=-7, rt=2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//     Then divu 7/0 -> HI and LO unchanged, busy still 10 cycles.
//   4 mthi 0x1234 and mtlo 0x5678 while idle -> next cycle rd_hl=0x1234 (read_hl=01) and 0x5678 (read_hl=10).
//     Repeat mtlo during busy -> LO unchanged.
//   5 start div, then assert reset on busy cycle 4 -> next cycle busy=0, HI=LO=0. A new mult then completes normally.
//   6 (`MULDIV_MACC_EN) HI=0, LO=0xFFFFFFFF; maddu rs=1, rt=1 -> HI=1, LO=0.
//     With the macro undefined, op 6 leaves busy=0 and HI/LO unchanged.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings and op-decode helpers for the E-stage multiply/divide unit.
// MULDIV_MACC_EN enables the madd/maddu/msub/msubu family.
package muldiv_pkg;

  localparam int unsigned OP_W  = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MADD  = 4'd5,
    OP_MADDU = 4'd6,
    OP_MSUB  = 4'd7,
    OP_MSUBU = 4'd8
  } hilo_op_e;

  localparam logic [1:0] HL_NONE = 2'b00;
  localparam logic [1:0] HL_HI   = 2'b01;
  localparam logic [1:0] HL_LO   = 2'b10;

  function automatic logic is_div(input logic [OP_W-1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_macc(input logic [OP_W-1:0] op);
    return (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

  function automatic logic is_msub(input logic [OP_W-1:0] op);
    return (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

  function automatic logic is_signed_op(input logic [OP_W-1:0] op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  function automatic logic op_legal(input logic [OP_W-1:0] op);
`ifdef MULDIV_MACC_EN
    return (op >= OP_MULT) && (op <= OP_MSUBU);
`else
    return (op >= OP_MULT) && (op <= OP_DIVU);
`endif
  endfunction

endpackage

// File: rtl/e_muldiv_unit_if.sv
// Handshake/data bundle between the E stage and the multiply/divide unit.
interface e_muldiv_unit_if;
  import muldiv_pkg::*;

  logic          start;
  logic [OP_W-1:0] hilo_op;
  logic [DW-1:0] rs_val;
  logic [DW-1:0] rt_val;
  logic [1:0]    write_hl;
  logic [1:0]    read_hl;
  logic          busy;
  logic          md_stall;
  logic [DW-1:0] hi_o;
  logic [DW-1:0] lo_o;
  logic [DW-1:0] rd_hl;

  modport master (
    output start, hilo_op, rs_val, rt_val, write_hl, read_hl,
    input  busy, md_stall, hi_o, lo_o, rd_hl
  );

  modport slave (
    input  start, hilo_op, rs_val, rt_val, write_hl, read_hl,
    output busy, md_stall, hi_o, lo_o, rd_hl
  );
endinterface

// File: rtl/muldiv_datapath.sv
// Combinational 64-bit product, quotient/remainder and (optionally) MACC adder.
// The accumulate adder only exists when MULDIV_MACC_EN is defined.
module muldiv_datapath
  import muldiv_pkg::*;
(
  input  logic [OP_W-1:0] op_i,
  input  logic [DW-1:0]   rs_i,
  input  logic [DW-1:0]   rt_i,
  input  logic [DW-1:0]   hi_i,
  input  logic [DW-1:0]   lo_i,
  output logic [DW-1:0]   res_hi_o,
  output logic [DW-1:0]   res_lo_o,
  output logic            div0_o
);

  logic          sgn;
  logic [63:0]   a64, b64, prod;
  logic          neg_a, neg_b;
  logic [DW-1:0] abs_a, abs_b, dvsr, uq, ur, q, r;
  logic [63:0]   acc;

  assign sgn  = is_signed_op(op_i);
  assign a64  = sgn ? {{32{rs_i[31]}}, rs_i} : {32'd0, rs_i};
  assign b64  = sgn ? {{32{rt_i[31]}}, rt_i} : {32'd0, rt_i};
  assign prod = a64 * b64;

  // Magnitude divide then sign-fix; 0x80000000/-1 falls out as 0x80000000 rem 0.
  assign neg_a  = sgn & rs_i[31];
  assign neg_b  = sgn & rt_i[31];
  assign abs_a  = neg_a ? (~rs_i + 32'd1) : rs_i;
  assign abs_b  = neg_b ? (~rt_i + 32'd1) : rt_i;
  assign div0_o = (rt_i == '0);
  assign dvsr   = div0_o ? 32'd1 : abs_b;
  assign uq     = abs_a / dvsr;
  assign ur     = abs_a % dvsr;
  assign q      = (neg_a ^ neg_b) ? (~uq + 32'd1) : uq;
  assign r      = neg_a ? (~ur + 32'd1) : ur;

`ifdef MULDIV_MACC_EN
  assign acc = is_msub(op_i) ? ({hi_i, lo_i} - prod) : ({hi_i, lo_i} + prod);
`else
  logic unused_hilo;
  assign unused_hilo = ^{hi_i, lo_i};
  assign acc         = prod;
`endif

  always_comb begin
    {res_hi_o, res_lo_o} = prod;
    if (is_div(op_i))       {res_hi_o, res_lo_o} = {r, q};
    else if (is_macc(op_i)) {res_hi_o, res_lo_o} = acc;
  end

endmodule

// File: rtl/e_muldiv_unit.sv
// E-stage multiply/divide unit: owns HI/LO, sequences multi-cycle ops, drives md_stall.
// MULDIV_MACC_EN adds madd/maddu/msub/msubu (see muldiv_pkg).
module e_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  e_muldiv_unit_if.slave   md
);

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e           state_q;
  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DW-1:0]    hi_q, lo_q, st_hi_q, st_lo_q;
  logic             st_upd_q;

  logic [DW-1:0]    dp_hi, dp_lo;
  logic             dp_div0;
  logic             launch;

  muldiv_datapath u_dp (
    .op_i     (md.hilo_op),
    .rs_i     (md.rs_val),
    .rt_i     (md.rt_val),
    .hi_i     (hi_q),
    .lo_i     (lo_q),
    .res_hi_o (dp_hi),
    .res_lo_o (dp_lo),
    .div0_o   (dp_div0)
  );

  assign launch = md.start & op_legal(md.hilo_op);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      st_hi_q  <= '0;
      st_lo_q  <= '0;
      st_upd_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // Results are staged at launch so later operand changes cannot leak in.
          if (launch) begin
            state_q  <= S_BUSY;
            busy_q   <= 1'b1;
            cnt_q    <= is_div(md.hilo_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            st_hi_q  <= dp_hi;
            st_lo_q  <= dp_lo;
            st_upd_q <= ~(is_div(md.hilo_op) & dp_div0);
          end else if (md.write_hl == HL_HI) begin
            hi_q <= md.rs_val;
          end else if (md.write_hl == HL_LO) begin
            lo_q <= md.rs_val;
          end
        end
        S_BUSY: begin
          if (cnt_q == CNT_W'(1)) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            if (st_upd_q) begin
              hi_q <= st_hi_q;
              lo_q <= st_lo_q;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign md.busy     = busy_q;
  assign md.md_stall = md.start | busy_q;
  assign md.hi_o     = hi_q;
  assign md.lo_o     = lo_q;
  assign md.rd_hl    = (md.read_hl == HL_HI) ? hi_q :
                       (md.read_hl == HL_LO) ? lo_q : '0;

endmodule

// File: tb/tb_e_muldiv_unit.sv
// Directed table-driven bench for e_muldiv_unit plus hand sequences for multi-cycle corners.
module tb_e_muldiv_unit;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  e_muldiv_unit_if md ();

  e_muldiv_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (md.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] pre_hi, pre_lo, rs, rt;
    int          exp_cyc;
    logic [31:0] exp_hi, exp_lo;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic preset(input logic [31:0] h, input logic [31:0] l);
    md.write_hl = HL_HI; md.rs_val = h; tick();
    md.write_hl = HL_LO; md.rs_val = l; tick();
    md.write_hl = HL_NONE;
  endtask

  task automatic count_busy(output int cyc);
    cyc = 0;
    while (md.busy === 1'b1 && cyc < 40) begin
      cyc++;
      tick();
    end
  endtask

  task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    md.start = 1'b1; md.hilo_op = op; md.rs_val = a; md.rt_val = b;
    tick();
    md.start = 1'b0; md.hilo_op = OP_NONE;
    md.rs_val = 32'hDEAD_BEEF; md.rt_val = 32'h0BAD_F00D;
  endtask

  initial begin
    int cyc;
    reset = 1'b1;
    md.start = 1'b0; md.hilo_op = OP_NONE; md.rs_val = '0; md.rt_val = '0;
    md.write_hl = HL_NONE; md.read_hl = HL_NONE;
    vecs.push_back('{"mult_neg",  OP_MULT,  32'h0, 32'h0, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA});
    vecs.push_back('{"multu",     OP_MULTU, 32'h0, 32'h0, 32'hFFFFFFFE, 32'd3, 5, 32'h00000002, 32'hFFFFFFFA});
    vecs.push_back('{"mult_min",  OP_MULT,  32'h0, 32'h0, 32'h80000000, 32'h80000000, 5, 32'h40000000, 32'h0});
    vecs.push_back('{"div_neg",   OP_DIV,   32'h0, 32'h0, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD});
    vecs.push_back('{"div_negdv", OP_DIV,   32'h0, 32'h0, 32'd7, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD});
    vecs.push_back('{"divu",      OP_DIVU,  32'h0, 32'h0, 32'hFFFFFFFF, 32'd16, 10, 32'h0000000F, 32'h0FFFFFFF});
    vecs.push_back('{"divu_zero", OP_DIVU,  32'hAAAA, 32'h5555, 32'd7, 32'd0, 10, 32'hAAAA, 32'h5555});
    vecs.push_back('{"div_zero",  OP_DIV,   32'h1111, 32'h2222, 32'hFFFFFFF9, 32'd0, 10, 32'h1111, 32'h2222});
    vecs.push_back('{"div_ovf",   OP_DIV,   32'h0, 32'h0, 32'h80000000, 32'hFFFFFFFF, 10, 32'h0, 32'h80000000});
    vecs.push_back('{"op_none",   OP_NONE,  32'h11, 32'h22, 32'd3, 32'd4, 0, 32'h11, 32'h22});
    vecs.push_back('{"op_bad",    4'd9,     32'h33, 32'h44, 32'd3, 32'd4, 0, 32'h33, 32'h44});
`ifdef MULDIV_MACC_EN
    vecs.push_back('{"maddu",     OP_MADDU, 32'h0, 32'hFFFFFFFF, 32'd1, 32'd1, 5, 32'h1, 32'h0});
    vecs.push_back('{"msub",      OP_MSUB,  32'h0, 32'h10, 32'd3, 32'd4, 5, 32'h0, 32'h4});
    vecs.push_back('{"madd_neg",  OP_MADD,  32'h0, 32'h1, 32'hFFFFFFFF, 32'd2, 5, 32'hFFFFFFFF, 32'hFFFFFFFF});
`else
    vecs.push_back('{"maddu_off", OP_MADDU, 32'h0, 32'hFFFFFFFF, 32'd1, 32'd1, 0, 32'h0, 32'hFFFFFFFF});
    vecs.push_back('{"msub_off",  OP_MSUB,  32'h5, 32'h10, 32'd3, 32'd4, 0, 32'h5, 32'h10});
`endif

    tick(); tick();
    reset = 1'b0;
    chk("rst_busy", {31'd0, md.busy}, 32'd0);
    chk("rst_hi", md.hi_o, 32'd0);
    chk("rst_lo", md.lo_o, 32'd0);
    chk("rst_stall", {31'd0, md.md_stall}, 32'd0);
    md.read_hl = HL_HI; #1;
    chk("rst_rdhl", md.rd_hl, 32'd0);
    md.read_hl = HL_NONE;

    foreach (vecs[i]) begin
      preset(vecs[i].pre_hi, vecs[i].pre_lo);
      launch(vecs[i].op, vecs[i].rs, vecs[i].rt);
      count_busy(cyc);
      chk({vecs[i].name, "_cyc"}, 32'(cyc), 32'(vecs[i].exp_cyc));
      chk({vecs[i].name, "_hi"}, md.hi_o, vecs[i].exp_hi);
      chk({vecs[i].name, "_lo"}, md.lo_o, vecs[i].exp_lo);
    end

    // mthi/mtlo and read mux
    preset(32'h1234, 32'h5678);
    md.read_hl = HL_HI; #1; chk("rd_hi", md.rd_hl, 32'h1234);
    md.read_hl = HL_LO; #1; chk("rd_lo", md.rd_hl, 32'h5678);
    md.read_hl = HL_NONE; #1; chk("rd_none", md.rd_hl, 32'h0);

    // stall is combinational on start; mtlo and a second start during busy are ignored
    md.start = 1'b1; md.hilo_op = OP_MULT; md.rs_val = 32'd2; md.rt_val = 32'd3; #1;
    chk("stall_comb", {31'd0, md.md_stall}, 32'd1);
    tick();
    md.start = 1'b1; md.hilo_op = OP_DIV; md.write_hl = HL_LO; md.rs_val = 32'hDEAD; md.read_hl = HL_LO;
    tick();
    chk("rd_busy", md.rd_hl, 32'h5678);
    chk("mtlo_busy", md.lo_o, 32'h5678);
    md.start = 1'b0; md.hilo_op = OP_NONE; md.write_hl = HL_NONE; md.read_hl = HL_NONE;
    count_busy(cyc);
    chk("inflight_cyc", 32'(cyc + 1), 32'd5);
    chk("inflight_hi", md.hi_o, 32'h0);
    chk("inflight_lo", md.lo_o, 32'd6);

    // start wins over a same-cycle mthi
    md.write_hl = HL_HI;
    launch(OP_MULT, 32'd5, 32'd5);
    md.write_hl = HL_NONE;
    chk("start_win_hi0", md.hi_o, 32'h0);
    count_busy(cyc);
    chk("start_win_lo", md.lo_o, 32'd25);
    chk("start_win_hi", md.hi_o, 32'h0);

    // reset on busy cycle 4 aborts the divide
    preset(32'h77, 32'h88);
    launch(OP_DIV, 32'd100, 32'd7);
    tick(); tick(); tick();
    chk("pre_rst_busy", {31'd0, md.busy}, 32'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("abort_busy", {31'd0, md.busy}, 32'd0);
    chk("abort_hi", md.hi_o, 32'h0);
    chk("abort_lo", md.lo_o, 32'h0);
    launch(OP_MULT, 32'd4, 32'd5);
    count_busy(cyc);
    chk("post_rst_cyc", 32'(cyc), 32'd5);
    chk("post_rst_lo", md.lo_o, 32'd20);
    chk("post_rst_hi", md.hi_o, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
